// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states and the
// queued command record.
package alu_seq_pkg;

   localparam int SEQ_TAG_W = 4;

   // Any opcode with bit 2 set is a multiply; OP_MUL is the canonical encoding.
   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_MUL = 3'b100
   } alu_op_e;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      GAP
   } seq_state_e;

   typedef struct packed {
      logic [7:0]           a;
      logic [7:0]           b;
      logic [2:0]           op;
      logic [SEQ_TAG_W-1:0] tag;
   } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with combinational head read and occupancy count.
module alu_cmd_fifo
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  cmd_t                     wr_data,
   input  logic                     pop,
   output cmd_t                     rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count alone
   // decide which entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drives the ALU start/done handshake one command at a
// time, and returns tagged results (or a timeout error) on a response port.
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = SEQ_TAG_W,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   input  logic [2:0]       cmd_op,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [2:0]       alu_op,
   output logic             alu_start,
   input  logic             alu_done,
   input  logic [15:0]      alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic             busy,
   output logic [15:0]      op_count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT);

   seq_state_e    state, state_nx;
   cmd_t          wr_cmd, head;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          ready_en;
   logic          pop, capture, abort, rsp_fire;
   logic [TW-1:0] wait_cnt;

   // ready_en holds cmd_ready low until the first cycle after reset.
   assign cmd_ready = ready_en && !fifo_full;
   assign rsp_valid = (state == RESP);
   assign busy      = (fifo_count != '0) || (state != IDLE);

   always_comb begin
      wr_cmd     = '0;
      wr_cmd.a   = cmd_a;
      wr_cmd.b   = cmd_b;
      wr_cmd.op  = cmd_op;
      wr_cmd.tag = cmd_tag;
   end

   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (cmd_valid && cmd_ready),
      .wr_data (wr_cmd),
      .pop     (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // NOTE: every output of this block gets a default first so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      capture  = 1'b0;
      abort    = 1'b0;
      rsp_fire = 1'b0;
      case (state)
         IDLE: if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = (head.op == OP_NOP) ? RESP : ISSUE;
         end
         ISSUE: state_nx = WAIT;
         WAIT: if (alu_done) begin
            capture  = 1'b1;
            state_nx = RESP;
         end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            abort    = 1'b1;
            state_nx = RESP;
         end
         RESP: if (rsp_ready) begin
            rsp_fire = 1'b1;
            state_nx = GAP;
         end
         GAP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         ready_en   <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         alu_start  <= 1'b0;
         rsp_result <= '0;
         rsp_tag    <= '0;
         rsp_err    <= 1'b0;
         op_count   <= '0;
         wait_cnt   <= '0;
      end else begin
         state    <= state_nx;
         ready_en <= 1'b1;
         if (pop) begin
            alu_a      <= head.a;
            alu_b      <= head.b;
            alu_op     <= head.op;
            rsp_tag    <= head.tag;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            alu_start  <= (head.op != OP_NOP);
         end
         if (state == ISSUE)     wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
         if (capture) begin
            rsp_result <= alu_result;
            alu_start  <= 1'b0;
         end
         // Result was already cleared at pop, so an abort only flags the error.
         if (abort) begin
            rsp_err   <= 1'b1;
            alu_start <= 1'b0;
         end
         if (rsp_fire) op_count <= op_count + 1'b1;
      end
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream command stage for the 8-bit ALU: buffers operand/opcode commands on a valid/ready interface and issues them one at a time using the ALU's start/done protocol. Holds operands stable until done, captures the 16-bit result, and returns it with the command tag on a valid/ready response interface. Handles no-op commands locally and reports a lost done as an error response.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, width of the command tag carried through to the response
TIMEOUT, 16, max cycles in WAIT for alu_done before aborting (>=8)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO not full
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_op  in  3  opcode: 000 nop, 001 add, 010 and, 011 xor, 1xx mul
cmd_tag  in  TAG_W  command id
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_op  out  3  ALU opcode
alu_start  out  1  ALU start
alu_done  in  1  ALU done
alu_result  in  16  ALU result
rsp_valid  out  1  response present
rsp_ready  in  1  response accepted
rsp_result  out  16  result
rsp_tag  out  TAG_W  tag of completed command
rsp_err  out  1  1 = ALU timeout, rsp_result = 0
busy  out  1  FIFO non-empty or FSM not IDLE
op_count  out  16  completed responses, wraps at 0xFFFF -> 0

Behaviour:
- Reset (reset_n=0 at edge): FIFO flushed, FSM -> IDLE. Outputs: alu_start=0, alu_a=alu_b=0, alu_op=0, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_err=0, op_count=0; cmd_ready=0 during reset, 1 in the cycle after reset. Reset mid-operation aborts without a response.
- FIFO: push on cmd_valid&cmd_ready; pop only in IDLE. Push and pop in the same cycle are allowed when full: the pop frees a slot for the next cycle only; cmd_ready is computed from the registered count.
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE with FIFO non-empty: pop the entry and register alu_a, alu_b and alu_op.
  - op=000: go to RESP with result 0 and err 0; alu_start is never raised.
  - Any other op: go to ISSUE and set alu_start=1.
- ISSUE: move to WAIT after 1 cycle. alu_start stays 1 and alu_a/b/op stay stable through WAIT.
- WAIT: a timeout counter runs.
  - On alu_done=1: capture alu_result, set alu_start=0, go to RESP.
  - If the counter reaches TIMEOUT: set alu_start=0, err=1, result=0, go to RESP.
- RESP: rsp_valid=1 with result, tag and err held stable until rsp_ready=1 (backpressure is unlimited). On handshake: increment op_count and go to GAP.
- GAP: one cycle with alu_start=0 so the ALU sees start low between commands, then go to IDLE.
- alu_done seen outside WAIT is ignored.
- Nominal latency with an empty FIFO and rsp_ready=1, counted from the cmd acceptance edge to the first rsp_valid cycle: add/and/xor 4, mul 7, nop 2.
- Throughput: at most one command per (ALU latency + 3) cycles.

Decomposition:
- Package alu_seq_pkg holds:
  - typedef enum alu_op_e {OP_NOP=3'b000, OP_ADD=3'b001, OP_AND=3'b010, OP_XOR=3'b011, OP_MUL=3'b100}
  - typedef enum seq_state_e {IDLE, ISSUE, WAIT, RESP, GAP}
  - typedef struct packed cmd_t {a, b, op, tag}, with tag width taken from a package constant
- One sub-module: alu_cmd_fifo (synchronous FIFO of cmd_t; DEPTH parameter; full/empty/count outputs).

Test Plan:
- Reset, then cmd add A=0x12 B=0x34 tag=1 -> rsp_result=0x0046, tag=1, err=0, rsp_valid 4 cycles after accept; op_count=1.
- cmd mul A=0xFF B=0xFF tag=2 -> rsp_result=0xFE01, 7 cycles after accept; alu_start high continuously until done, then low for >=1 cycle.
- Back-to-back pushes: and 0xF0,0x3C; xor 0xAA,0x55; nop; mul 3,4 with tags 3-6, rsp_ready=1 -> responses in order 0x0030, 0x00FF, 0x0000, 0x000C. cmd_ready=0 after DEPTH entries queue; alu_start never rises for the nop.
- Hold alu_done=0 (ALU stub) on an add -> after TIMEOUT cycles in WAIT: rsp_err=1, rsp_result=0, alu_start dropped; the next command completes normally.
- rsp_ready=0 for 10 cycles during RESP -> rsp_valid, result and tag stable; the FIFO keeps accepting until full; no second alu_start issued.
- Assert reset_n=0 for one cycle while in WAIT on a mul -> all outputs at reset values the next cycle, no response emitted, op_count=0, busy=0.
